// File: rtl/pe_pkg.sv
// pe_pkg: port numbering, header field positions and XY route helper for the mesh router.
package pe_pkg;
  typedef enum logic [2:0] {EAST = 3'd0, WEST = 3'd1, NORTH = 3'd2, SOUTH = 3'd3, LOCAL = 3'd4} port_e;
  localparam int NPORT = 5;
  localparam int X_HI = 15;
  localparam int X_LO = 8;
  localparam int Y_HI = 7;
  localparam int Y_LO = 0;
  function automatic port_e xy_route(input logic [15:0] hdr, input logic [15:0] addr);
    logic [7:0] dx, dy, lx, ly;
    dx = hdr[X_HI:X_LO];
    dy = hdr[Y_HI:Y_LO];
    lx = addr[X_HI:X_LO];
    ly = addr[Y_HI:Y_LO];
    return dx > lx ? EAST : dx < lx ? WEST : dy > ly ? NORTH : dy < ly ? SOUTH : LOCAL;
  endfunction
endpackage

// File: rtl/interface_pe.sv
// interface_pe: all link wires of one router, five ports each.
interface interface_pe #(parameter int FLIT_WIDTH = 32) ();
  logic [pe_pkg::NPORT-1:0][FLIT_WIDTH-1:0] data_i, data_o;
  logic [pe_pkg::NPORT-1:0] rx, credit_o, clock_rx, tx, credit_i, clock_tx;
  modport PE(input data_i, rx, clock_rx, credit_i, output data_o, credit_o, tx, clock_tx);
endinterface

// File: rtl/pe_input_buffer.sv
// pe_input_buffer: per-input FIFO with credit, packet-position tracking and last-flit flag.
module pe_input_buffer import pe_pkg::*; #(
  parameter int FLIT_WIDTH = 32,
  parameter int BUFFER_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_i,
  input  logic                  rx_i,
  output logic                  credit_o,
  input  logic                  rd_i,
  output logic [FLIT_WIDTH-1:0] head_o,
  output logic                  valid_o,
  output logic                  header_o,
  output logic                  last_o
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  typedef enum logic [1:0] {S_HDR, S_SIZE, S_BODY} state_e;
  logic [FLIT_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [FLIT_WIDTH-1:0] left_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic ready_q, wr;
  state_e state_q;
  // ready_q holds credit low until the first edge after reset release
  assign credit_o = ready_q && cnt_q != (AW+1)'(BUFFER_DEPTH);
  assign wr = rx_i && credit_o;
  assign valid_o = cnt_q != '0;
  assign head_o = mem_q[rd_q];
  assign header_o = state_q == S_HDR;
  assign last_o = (state_q == S_SIZE && head_o == '0) || (state_q == S_BODY && left_q == FLIT_WIDTH'(1));
  always_ff @(posedge clk) if (wr) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ready_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      left_q <= '0;
      state_q <= S_HDR;
    end else begin
      ready_q <= 1'b1;
      wr_q <= wr_q + AW'(wr);
      rd_q <= rd_q + AW'(rd_i);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd_i);
      if (rd_i)
        case (state_q)
          S_HDR: state_q <= S_SIZE;
          S_SIZE: begin
            left_q <= head_o;
            state_q <= head_o == '0 ? S_HDR : S_BODY;
          end
          default: begin
            left_q <= left_q - 1'b1;
            state_q <= left_q == FLIT_WIDTH'(1) ? S_HDR : S_BODY;
          end
        endcase
    end
endmodule

// File: rtl/pe.sv
// pe: 5-port wormhole mesh router with XY routing, round-robin arbitration and credit flow control.
module pe import pe_pkg::*; #(
  parameter int          MEMORY_BUS_WIDTH = 32,
  parameter int          FLIT_WIDTH       = 32,
  parameter logic [15:0] ADDRESS          = 16'h0000,
  parameter int          MEMORY_SIZE      = 1024,
  parameter int          MEMORY_BASE      = 0,
  parameter int          BUFFER_DEPTH     = 16
) (
  input logic        clock,
  input logic        reset,
  interface_pe.PE    router
);
  logic [NPORT-1:0][FLIT_WIDTH-1:0] head;
  logic [NPORT-1:0] valid, header, last, rd, req, rel_in, rel_out, tx, conn_q, busy_q;
  port_e dest [NPORT];
  port_e in_out_q [NPORT];
  port_e out_in_q [NPORT];
  port_e ptr_q, gnt, idx;
  logic gnt_v;
  logic unused;
  assign unused = ^{router.clock_rx, MEMORY_BUS_WIDTH[0], MEMORY_SIZE[0], MEMORY_BASE[0]};
  assign router.clock_tx = {NPORT{clock}};
  assign router.tx = tx;
  for (genvar i = 0; i < NPORT; i++) begin : g_port
    pe_input_buffer #(.FLIT_WIDTH(FLIT_WIDTH), .BUFFER_DEPTH(BUFFER_DEPTH)) u_buf (
      .clk(clock), .rst_n(reset), .data_i(router.data_i[i]), .rx_i(router.rx[i]),
      .credit_o(router.credit_o[i]), .rd_i(rd[i]), .head_o(head[i]), .valid_o(valid[i]),
      .header_o(header[i]), .last_o(last[i])
    );
    assign dest[i] = xy_route(head[i][15:0], ADDRESS);
    assign req[i] = valid[i] && header[i] && !conn_q[i];
    assign rd[i] = conn_q[i] && tx[in_out_q[i]] && router.credit_i[in_out_q[i]];
    assign rel_in[i] = rd[i] && last[i];
    assign tx[i] = busy_q[i] && valid[out_in_q[i]];
    assign rel_out[i] = busy_q[i] && rel_in[out_in_q[i]];
    assign router.data_o[i] = tx[i] ? head[out_in_q[i]] : '0;
  end
  // an output freed on this edge may be granted again on the same edge
  always_comb begin
    gnt_v = 1'b0;
    gnt = EAST;
    idx = EAST;
    for (int k = 1; k <= NPORT; k++) begin
      idx = port_e'(3'((int'(ptr_q) + k) % NPORT));
      if (!gnt_v && req[idx] && (!busy_q[dest[idx]] || rel_out[dest[idx]])) begin
        gnt_v = 1'b1;
        gnt = idx;
      end
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      conn_q <= '0;
      busy_q <= '0;
      ptr_q <= EAST;
      for (int i = 0; i < NPORT; i++) begin
        in_out_q[i] <= EAST;
        out_in_q[i] <= EAST;
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (rel_in[i]) conn_q[i] <= 1'b0;
        if (rel_out[i]) busy_q[i] <= 1'b0;
      end
      if (gnt_v) begin
        conn_q[gnt] <= 1'b1;
        in_out_q[gnt] <= dest[gnt];
        busy_q[dest[gnt]] <= 1'b1;
        out_in_q[dest[gnt]] <= gnt;
        ptr_q <= gnt;
      end
    end
endmodule

// File: tb/tb_pe.sv
// tb_pe: scoreboard bench for the mesh router at address (1,1).
module tb_pe;
  typedef logic [31:0] flit_t;
  typedef flit_t pkt_t [$];
  localparam int E = 0, W = 1, N = 2, S = 3, L = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0, cyc = 0, hdr_cyc = 0, first_tx = -1;
  int acc [5];
  flit_t exp_q [5][$];
  flit_t mon_e;
  interface_pe #(.FLIT_WIDTH(32)) pe_if ();
  pe #(.ADDRESS(16'h0101)) dut (.clock(clk), .reset(rst_n), .router(pe_if));
  always #5 clk = ~clk;
  assign pe_if.clock_rx = {5{clk}};
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n)
      for (int o = 0; o < 5; o++)
        if (pe_if.tx[o] && pe_if.credit_i[o]) begin
          total++;
          if (o == L && first_tx < 0) first_tx = cyc;
          if (exp_q[o].size() == 0) begin
            bad++;
            $display("FAIL unexpected_flit port=%0d got %h required none", o, pe_if.data_o[o]);
          end else begin
            mon_e = exp_q[o].pop_front();
            if (pe_if.data_o[o] !== mon_e) begin
              bad++;
              $display("FAIL flit port=%0d got %h required %h", o, pe_if.data_o[o], mon_e);
            end
          end
        end

  function automatic pkt_t mk_pkt(input flit_t hdr, input int n, input flit_t base);
    pkt_t p;
    p.push_back(hdr);
    p.push_back(flit_t'(n));
    for (int i = 1; i <= n; i++) p.push_back(base + flit_t'(i));
    return p;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int o = 0; o < 5; o++) s += exp_q[o].size();
    return s;
  endfunction

  task automatic push_exp(input int o, input pkt_t p);
    foreach (p[i]) exp_q[o].push_back(p[i]);
  endtask

  task automatic send_pkt(input int p, input pkt_t pk);
    foreach (pk[i]) begin
      int t;
      t = 0;
      pe_if.rx[p] = 1'b1;
      pe_if.data_i[p] = pk[i];
      @(negedge clk);
      while (!pe_if.credit_o[p] && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!pe_if.credit_o[p]) begin
        total++;
        bad++;
        $display("FAIL send_timeout port=%0d flit=%0d got credit 0 required 1", p, i);
        pe_if.rx[p] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      acc[p]++;
      if (i == 0) hdr_cyc = cyc;
    end
    pe_if.rx[p] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (pending() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (pending() != 0) begin
      bad++;
      $display("FAIL drain_%s got %0d pending required 0", name, pending());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pe_if.rx = '0;
    pe_if.data_i = '0;
    pe_if.credit_i = '1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total += 3;
      if (pe_if.tx !== 5'b0) begin bad++; $display("FAIL reset_tx got %b required 00000", pe_if.tx); end
      if (pe_if.data_o !== '0) begin bad++; $display("FAIL reset_data got %h required 0", pe_if.data_o); end
      if (pe_if.credit_o !== 5'b0) begin bad++; $display("FAIL reset_credit got %b required 00000", pe_if.credit_o); end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (pe_if.credit_o !== 5'b11111) begin bad++; $display("FAIL credit_after_release got %b required 11111", pe_if.credit_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_local();
    pkt_t p;
    p = mk_pkt(32'h0000_0101, 2, 32'hAAAA_0000);
    push_exp(L, p);
    first_tx = -1;
    send_pkt(L, p);
    wait_drain("local");
    total++;
    if (first_tx - hdr_cyc != 1) begin
      bad++;
      $display("FAIL local_latency got %0d required 1 cycle(s) from header accept to first tx", first_tx - hdr_cyc);
    end
  endtask

  task automatic test_xy();
    flit_t hdrs [4];
    int outs [4];
    pkt_t p;
    hdrs = '{32'h0000_0201, 32'h0000_0001, 32'h0000_0102, 32'h0000_0100};
    outs = '{E, W, N, S};
    for (int k = 0; k < 4; k++) begin
      p = mk_pkt(hdrs[k], 1, 32'h5000_0000 + flit_t'(k << 8));
      push_exp(outs[k], p);
      send_pkt(L, p);
    end
    wait_drain("xy");
  endtask

  task automatic test_contention();
    pkt_t pw, ps;
    pw = mk_pkt(32'h0000_0101, 1, 32'hB000_0000);
    ps = mk_pkt(32'h0000_0101, 1, 32'hC000_0000);
    push_exp(L, pw);
    push_exp(L, ps);
    fork
      send_pkt(W, pw);
      send_pkt(S, ps);
    join
    wait_drain("contention");
  endtask

  task automatic test_backpressure();
    pkt_t p;
    pe_if.credit_i[E] = 1'b0;
    p = mk_pkt(32'h0000_0201, 18, 32'hD000_0000);
    push_exp(E, p);
    acc[N] = 0;
    fork
      send_pkt(N, p);
    join_none
    repeat (30) @(negedge clk);
    total += 2;
    if (pe_if.credit_o[N] !== 1'b0) begin bad++; $display("FAIL bp_credit got %b required 0", pe_if.credit_o[N]); end
    if (acc[N] != 16) begin bad++; $display("FAIL bp_accepted got %0d required 16", acc[N]); end
    @(posedge clk);
    #1 pe_if.credit_i[E] = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_empty_payload();
    pkt_t p1, p2;
    p1 = mk_pkt(32'h0000_0100, 0, 32'h0);
    p2 = mk_pkt(32'h0000_0102, 1, 32'hE000_0000);
    push_exp(S, p1);
    push_exp(N, p2);
    send_pkt(E, p1);
    send_pkt(E, p2);
    wait_drain("empty_payload");
  endtask

  task automatic test_reset_mid();
    pkt_t p;
    pe_if.credit_i[E] = 1'b0;
    p = mk_pkt(32'h0000_0201, 3, 32'hF000_0000);
    send_pkt(W, p);
    repeat (2) @(negedge clk);
    total++;
    if (pe_if.tx[E] !== 1'b1) begin bad++; $display("FAIL mid_stall_tx got %b required 1", pe_if.tx[E]); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total += 3;
    if (pe_if.tx !== 5'b0) begin bad++; $display("FAIL mid_reset_tx got %b required 00000", pe_if.tx); end
    if (pe_if.credit_o !== 5'b0) begin bad++; $display("FAIL mid_reset_credit got %b required 00000", pe_if.credit_o); end
    if (pe_if.data_o !== '0) begin bad++; $display("FAIL mid_reset_data got %h required 0", pe_if.data_o); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pe_if.credit_i[E] = 1'b1;
    @(posedge clk);
    #1;
    p = mk_pkt(32'h0000_0201, 1, 32'h1234_0000);
    push_exp(E, p);
    send_pkt(W, p);
    wait_drain("reset_mid");
  endtask

  initial begin
    for (int o = 0; o < 5; o++) acc[o] = 0;
    test_reset();
    test_local();
    test_xy();
    test_contention();
    test_backpressure();
    test_empty_payload();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe.md
Name: pe

Overview:
- Processing-element node of the 2-D mesh NoC: a 5-port Hermes-style wormhole router (EAST, WEST, NORTH, SOUTH, LOCAL) with XY routing, per-input FIFOs, round-robin arbitration and credit-based flow control.
- All router wires are grouped in interface interface_pe (modport PE); clock and reset enter separately.
- Tiled NOC_DIM_X x NOC_DIM_Y; EAST/WEST link x±1, NORTH/SOUTH link y±1. The LOCAL port is exposed for the core or harness.

Parameters:
- MEMORY_BUS_WIDTH, 32, width of the local memory bus. Propagated only; no memory in this revision.
- FLIT_WIDTH, 32, flit width in bits (minimum 16).
- ADDRESS, 0, router address: [15:8] = X, [7:0] = Y.
- MEMORY_SIZE, 1024, words of local memory. Propagated only.
- MEMORY_BASE, 0, local memory base address. Propagated only.
- BUFFER_DEPTH, 16, flits per input FIFO. Power of two, at least 2.

Ports:
Ports are 5-element arrays indexed EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_i  in  5xFLIT_WIDTH  incoming flit per port.
- rx  in  5  incoming flit valid.
- credit_o  out  5  input FIFO can accept a flit.
- clock_rx  in  5  upstream clock. Ignored: single clock domain.
- data_o  out  5xFLIT_WIDTH  outgoing flit per port.
- tx  out  5  outgoing flit valid.
- credit_i  in  5  downstream can accept a flit.
- clock_tx  out  5  copy of clock.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0), applied immediately:
  - FIFOs empty, arbiter pointer = EAST, all connections released.
  - tx=0, data_o=0, credit_o=0.
- The cycle after reset release, credit_o=1 on all ports.
- Packet format:
  - flit0 = header; target X = [15:8], Y = [7:0].
  - flit1 = payload size N.
  - then N payload flits; total N+2. N=0 is legal (2-flit packet).
- Link handshake: a flit transfers on a rising edge when tx=1 and credit_i=1 (output), or rx=1 and credit_o=1 (input).
- credit_o = FIFO not full. rx while full is ignored: the flit is dropped and the sender is at fault.
- tx=1 exactly while the connected input FIFO is non-empty. data_o shows the FIFO head combinationally through the crossbar.
- XY routing on header, with local (lx, ly) from ADDRESS:
  - dx > lx → EAST; dx < lx → WEST.
  - otherwise dy > ly → NORTH; dy < ly → SOUTH.
  - otherwise LOCAL.
- Arbitration:
  - At most one new connection granted per cycle.
  - Candidates: inputs whose FIFO head is a header and which have no connection.
  - Round-robin from the port after the last granted one.
  - A request whose output is busy is skipped that cycle and retried later.
- Latency: header written at edge k → request visible cycle k+1 → grant at edge k+1 → tx asserted from cycle k+1 after that edge. Minimum is 2 edges from input accept to output transfer.
- Wormhole switching:
  - Each input keeps a flit counter: the size flit loads N, and each forwarded payload flit decrements it.
  - The connection (input→output, output busy) is released on the edge the last flit transfers.
  - The next header on that input may request from the following cycle.
- Simultaneous events:
  - Write and read of the same FIFO in one cycle are both performed.
  - A FIFO that is full and read in the same cycle still shows credit_o=0 that cycle.
  - Release and a new grant of the same output in the same cycle are allowed.
- Pointer wrap: FIFO pointers are modulo BUFFER_DEPTH.
- Blocked paths: a packet routed to a grounded border port (credit_i=0) stalls indefinitely and blocks its input. No timeout.
- Reset mid-packet discards all in-flight flits.

Decomposition:
- Package pe_pkg: port enum (EAST..LOCAL), NPORT=5, header field positions (X_HI=15, X_LO=8, Y_HI=7, Y_LO=0).
- Sub-module pe_input_buffer: FIFO, credit_o, header detect, flit counter, last-flit flag. Instantiated 5 times.
- pe itself holds the routing/arbitration logic and the crossbar.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → tx=0 and data_o=0 during reset; credit_o=5'b11111 one cycle after release.
- Local delivery: ADDRESS=0x0000, inject on LOCAL header 0x0000_0000, size 2, payload 0xAAAA0001 and 0xAAAA0002 with credit_i=1 → same 4 flits in order on LOCAL data_o; first tx no earlier than 2 edges after header accept.
- XY routing: ADDRESS=0x0101, headers to (2,1), (0,1), (1,2), (1,0) → exits EAST, WEST, NORTH, SOUTH respectively.
- Contention: WEST and SOUTH both send 3-flit packets to LOCAL in the same cycle → WEST packet complete first (round-robin from EAST), then SOUTH, no interleaving.
- Backpressure: 20-flit packet to EAST with credit_i[EAST]=0 → credit_o of the input drops to 0 after 16 accepted flits. Raising credit_i drains all 20 flits intact.
- Empty payload: size 0 packet → 2 flits forwarded, and the connection is released so a following packet on the same input is routed.
